puf_challenge_sequencer: RTL and testbench

PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

---
 rtl/puf_pkg.sv | 23 ++
 rtl/puf_lfsr8.sv | 24 ++
 rtl/puf_challenge_sequencer.sv | 158 +++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF challenge sequencer.
// Holds the sequencer state encoding and the challenge LFSR definition.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LAUNCH,
        SETTLE,
        CAPTURE,
        NEXT,
        DONE
    } puf_state_t;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_POLY          = 8'hB8;
    localparam logic [7:0] LFSR_SEED_ZERO_SUB = 8'h01;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? LFSR_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/puf_lfsr8.sv
// 8-bit Galois LFSR that generates the challenge sequence.
// A load takes priority over a step; the all-zero lock-up seed is the caller's concern.
module puf_lfsr8
    import puf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       step,
    output logic [7:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= 8'h00;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: steps an LFSR through N_CHAL challenges and collects one bit each.
// Define PUF_MAJORITY_VOTE_EN to evaluate every challenge VOTES times and keep the majority.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int N_CHAL        = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int VOTES         = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        seed,
    output logic [7:0]        ch,
    output logic              mux_in,
    output logic              arb_rst,
    input  logic              resp,
    output logic              busy,
    output logic              done,
    output logic [N_CHAL-1:0] resp_word
);

    localparam int IDX_W = (N_CHAL > 1) ? $clog2(N_CHAL) : 1;

    puf_state_t       state;
    logic [7:0]       cnt;
    logic [IDX_W-1:0] idx;
    logic             res_bit;
    logic             resp_meta;
    logic             resp_s;
    logic             last_chal;
    logic             lfsr_load;
    logic             lfsr_step;
    logic [7:0]       load_val;

    // resp comes from the free-running arbiter and has no timing relation to clk
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_meta <= 1'b0;
            resp_s    <= 1'b0;
        end else begin
            resp_meta <= resp;
            resp_s    <= resp_meta;
        end
    end

    assign last_chal = (idx == IDX_W'(N_CHAL - 1));
    assign load_val  = (seed == 8'h00) ? LFSR_SEED_ZERO_SUB : seed;
    assign lfsr_load = (state == IDLE) && start;
    assign lfsr_step = (state == NEXT) && !last_chal;

    puf_lfsr8 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (load_val),
        .step     (lfsr_step),
        .state    (ch)
    );

`ifdef PUF_MAJORITY_VOTE_EN
    logic [3:0] vote_idx;
    logic [3:0] ones_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            idx       <= '0;
            res_bit   <= 1'b0;
            resp_word <= '0;
            mux_in    <= 1'b0;
            arb_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
            vote_idx  <= 4'd0;
            ones_cnt  <= 4'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        resp_word <= '0;
                        cnt       <= 8'd0;
                        busy      <= 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
                        vote_idx  <= 4'd0;
                        ones_cnt  <= 4'd0;
`endif
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (cnt == 8'd1) begin
                        arb_rst <= 1'b0;
                        mux_in  <= 1'b1;
                        state   <= LAUNCH;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                LAUNCH: begin
                    cnt   <= 8'd0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == 8'(SETTLE_CYCLES - 1)) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                CAPTURE: begin
                    mux_in  <= 1'b0;
                    arb_rst <= 1'b1;
                    cnt     <= 8'd0;
`ifdef PUF_MAJORITY_VOTE_EN
                    if (vote_idx == 4'(VOTES - 1)) begin
                        res_bit  <= (ones_cnt + {3'b000, resp_s}) > 4'(VOTES / 2);
                        vote_idx <= 4'd0;
                        ones_cnt <= 4'd0;
                        state    <= NEXT;
                    end else begin
                        vote_idx <= vote_idx + 4'd1;
                        ones_cnt <= ones_cnt + {3'b000, resp_s};
                        state    <= CLEAR;
                    end
`else
                    res_bit <= resp_s;
                    state   <= NEXT;
`endif
                end
                NEXT: begin
                    resp_word[idx] <= res_bit;
                    if (last_chal) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= CLEAR;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer (N_CHAL=4, SETTLE_CYCLES=2, VOTES=5).
// The PUF is modelled as resp = ^ch, or as a per-launch bit pattern in voting builds.
module tb_puf_challenge_sequencer;

    localparam int N = 4;
    localparam int S = 2;
    localparam int V = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   seed = 8'h00;
    logic [7:0]   ch;
    logic         mux_in;
    logic         arb_rst;
    logic         resp;
    logic         busy;
    logic         done;
    logic [N-1:0] resp_word;

    int pass_cnt = 0;
    int total    = 0;
    int cyc;

    int         nl = 0;
    int         stab_err = 0;
    logic [7:0] launch_ch [256];
    logic       mux_q = 1'b0;
    logic [7:0] ch_q = 8'h00;

    bit          vote_mode = 1'b0;
    int          vbase = 0;
    logic [19:0] pat = 20'h0;

    logic [7:0] exp_seq [2][4] = '{'{8'hA5, 8'hEA, 8'h75, 8'h82},
                                   '{8'h01, 8'hB8, 8'h5C, 8'h2E}};
    logic [3:0] exp_word [2] = '{4'h6, 4'h1};

    puf_challenge_sequencer #(
        .N_CHAL        (N),
        .SETTLE_CYCLES (S),
        .VOTES         (V)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .ch        (ch),
        .mux_in    (mux_in),
        .arb_rst   (arb_rst),
        .resp      (resp),
        .busy      (busy),
        .done      (done),
        .resp_word (resp_word)
    );

    always #5 clk = ~clk;

    always_comb begin
        resp = ^ch;
        if (vote_mode && (nl > vbase) && (nl - vbase <= 20)) resp = pat[nl - vbase - 1];
    end

    // Record the challenge at every launch and flag any change while the chain is driven
    always @(negedge clk) begin
        if (mux_in && !mux_q && nl < 256) begin
            launch_ch[nl] = ch;
            nl++;
        end
        if (mux_in && mux_q && ch !== ch_q) stab_err++;
        mux_q = mux_in;
        ch_q  = ch;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run(input logic [7:0] sd, input int t, input bit mid);
        int c;
        int base;
        int se0;
        base = nl;
        se0  = stab_err;
        @(negedge clk);
        seed  = sd;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("first_ch", 32'(ch), 32'(exp_seq[t][0]));
        while (!done && c < 200) begin
            if (mid) begin
                if (c == 10) begin
                    start = 1'b1;
                    seed  = 8'h00;
                end else begin
                    start = 1'b0;
                end
            end
            @(posedge clk); #1;
            c++;
        end
        chk("done_latency", 32'(c), 32'd29);
        chk("done_high", 32'(done), 32'd1);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        chk("resp_word", 32'(resp_word), 32'(exp_word[t]));
        chk("launch_count", 32'(nl - base), 32'd4);
        for (int i = 0; i < 4; i++) chk("launch_ch", 32'(launch_ch[base + i]), 32'(exp_seq[t][i]));
        chk("ch_stable", 32'(stab_err - se0), 32'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("resp_word_held", 32'(resp_word), 32'(exp_word[t]));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_arb_rst", 32'(arb_rst), 32'd1);
        chk("rst_mux_in", 32'(mux_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_resp_word", 32'(resp_word), 32'd0);
        chk("rst_ch", 32'(ch), 32'd0);

`ifdef PUF_MAJORITY_VOTE_EN
        pat       = {5'b00000, 5'b00111, 5'b10100, 5'b01101};
        vbase     = nl;
        vote_mode = 1'b1;
        @(negedge clk);
        seed  = 8'hA5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("vote_latency", 32'(cyc), 32'd125);
        chk("vote_done", 32'(done), 32'd1);
        chk("vote_resp_word", 32'(resp_word), 32'h5);
        chk("vote_launches", 32'(nl - vbase), 32'd20);
        chk("vote_ch0", 32'(launch_ch[vbase + 4]), 32'hA5);
        chk("vote_ch1", 32'(launch_ch[vbase + 5]), 32'hEA);
        chk("vote_ch_stable", 32'(stab_err), 32'd0);
        vote_mode = 1'b0;
`else
        run(8'hA5, 0, 1'b0);
        run(8'h00, 1, 1'b0);
        run(8'hA5, 0, 1'b1);

        // Reset in the middle of the second challenge's settle window
        @(negedge clk);
        seed  = 8'h00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 11) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_mux_in", 32'(mux_in), 32'd1);
        chk("mid_resp_word", 32'(resp_word), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_mux_in", 32'(mux_in), 32'd0);
        chk("mid_rst_arb_rst", 32'(arb_rst), 32'd1);
        chk("mid_rst_resp_word", 32'(resp_word), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ch", 32'(ch), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(8'hA5, 0, 1'b0);

        // start held across the DONE cycle is only taken once back in IDLE
        @(negedge clk);
        seed  = 8'h00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("pre_done", 32'(done), 32'd1);
        seed  = 8'hA5;
        start = 1'b1;
        @(posedge clk); #1;
        chk("start_in_done_ignored", 32'(busy), 32'd0);
        chk("word_kept_in_idle", 32'(resp_word), 32'h1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_after_done_taken", 32'(busy), 32'd1);
        chk("word_cleared_on_start", 32'(resp_word), 32'd0);
        chk("restart_ch", 32'(ch), 32'hA5);
        cyc = 1;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("restart_resp_word", 32'(resp_word), 32'h6);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
